// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit add/subtract sequencer built around one shared
// 4-bit ripple-carry adder. One nibble is processed per clock, and the carry
// is registered between nibbles. Valid/ready handshakes are used on both the
// request side and the result side.

// 4-bit ripple-carry adder slice shared by the sequencer.
module ripple_carry_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    // Ripple the carry through the four bit positions.
    always_comb begin
        logic [4:0] c;
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < 4; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = c[4];
    end

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NS = WIDTH / 4;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // holds ~op_b for subtraction
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       nib_a, nib_b, nib_s;
    logic             nib_c;

    // The current nibble of each operand feeds the shared adder.
    assign nib_a = a_q[4*idx_q +: 4];
    assign nib_b = b_q[4*idx_q +: 4];

    ripple_carry_adder u_adder (
        .a_i (nib_a),
        .b_i (nib_b),
        .c_i (carry_q),
        .s_o (nib_s),
        .c_o (nib_c)
    );

    // State and datapath registers; reset clears everything so an aborted
    // operation never leaves a partial result on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and datapath update: accept in IDLE, one nibble per cycle in
    // RUN, hold everything in DONE until the consumer takes the result.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;   // +1 completes the two's-complement negate
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[4*idx_q +: 4] = nib_s;
                carry_d                = nib_c;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    cout_d  = nib_c;
                    // Overflow: operands agree in sign but the sum does not.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (nib_s[3] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is masked by reset so it reads 0 while rst_n is low.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=16): directed cases, back-pressure,
// mid-operation reset and a randomized back-to-back run against a model.
module tb_serial_add_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the operand values.
    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
        int ua, ub, sa, sb, full, sres;
        logic [W-1:0] r;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub;
            c    = (full >= 65536);
            sres = sa + sb;
        end
        r = W'(full);
        o = (sres > 32767) || (sres < -32768);
        return {c, o, r};
    endfunction

    // Wait (bounded) for out_valid, sampling 1 time unit after each edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] er, input logic ec,
                         input logic eo);
        int lat;
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        sub = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_carry"}, 32'(carry_out), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [17:0] q[$];
        logic [17:0] e;
        logic [W-1:0] held;
        int lat, cyc, done, last;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        sub = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        do_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("add_1234",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("sub_5_7",    16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Stray out_ready pulse in IDLE must not disturb anything.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stray_ready_in_ready", 32'(in_ready), 32'd1);
        check("stray_ready_valid", 32'(out_valid), 32'd0);

        // Back-pressure with operand changes during RUN
        in_valid = 1'b1;
        op_a = 16'h1234;
        op_b = 16'h4321;
        sub = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        op_a = 16'hFFFF;
        op_b = 16'h0F0F;
        sub = 1'b1;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd3);
        check("bp_result", 32'(result), 32'h5555);
        held = result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", 32'(result), 32'(held));
            check("bp_hold_carry", 32'(carry_out), 32'd0);
            check("bp_hold_ovf", 32'(overflow), 32'd0);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset while RUN is at idx=2
        in_valid = 1'b1;
        op_a = 16'h1234;
        op_b = 16'h4321;
        sub = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_partial_nonzero", 32'(result != 16'h0000), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_carry", 32'(carry_out), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_hold_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        do_op("post_rst_1_1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Back-to-back random run
        in_valid = 1'b1;
        out_ready = 1'b1;
        op_a = W'($urandom);
        op_b = W'($urandom);
        sub = 1'($urandom);
        cyc = 0;
        done = 0;
        last = 0;
        while (done < 500 && cyc < 3200) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("b2b_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("b2b_result", 32'(result), 32'(e[15:0]));
                    check("b2b_carry", 32'(carry_out), 32'(e[17]));
                    check("b2b_ovf", 32'(overflow), 32'(e[16]));
                end
                if (done > 0) check("b2b_period", 32'(cyc - last), 32'd6);
                last = cyc;
                done++;
            end
            if (in_ready) begin
                q.push_back(model(op_a, op_b, sub));
            end else begin
                op_a = W'($urandom);
                op_b = W'($urandom);
                sub = 1'($urandom);
            end
        end
        check("b2b_completions", 32'(done), 32'd500);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by stepping one shared 4-bit ripple_carry_adder instance through the operands, one nibble per clock.
- The carry is registered between nibbles.
- Valid/ready handshakes on the input and output sides.
- Sits between a requester and the existing 4-bit adder datapath, so wide arithmetic can reuse the small adder instead of a WIDTH-bit combinational chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. NS = WIDTH/4 slices.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- sub  input  1  1 = A-B, 0 = A+B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference
- carry_out  output  1  final carry; for sub, 1 = no borrow
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset: rst_n low asynchronously forces the following, and aborts any operation in progress with no partial result emitted:
  - state = IDLE
  - in_ready = 0 during reset, 1 on the first cycle after release
  - out_valid = 0, result = 0, carry_out = 0, overflow = 0
  - internal slice index = 0, carry register = 0
- State IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, the block latches op_a, op_b and sub.
  - If sub=1, the B register is loaded with ~op_b.
  - The carry register is loaded with sub, index = 0, and the state goes to RUN.
  - in_ready drops to 0 the cycle after acceptance.
- State RUN:
  - The adder instance is driven with A[4*idx+:4], B[4*idx+:4] and the carry register.
  - Each edge:
    - the adder sum is written into result[4*idx+:4];
    - the carry register takes the adder carry;
    - idx increments.
  - On the edge where idx = NS-1:
    - state goes to DONE and out_valid is set;
    - carry_out takes the final adder carry;
    - overflow = (A[MSB] == B_eff[MSB]) && (sum MSB != A[MSB]), where B_eff is the possibly inverted B.
- State DONE:
  - out_valid = 1; result, carry_out and overflow are held stable.
  - On an edge with out_ready=1, out_valid goes to 0 and the state returns to IDLE.
  - While out_ready=0, everything holds indefinitely.
- Latency: if acceptance occurs at edge E0, out_valid is high after edge E_NS, i.e. exactly NS cycles (4 for WIDTH=16). There is one additional cycle (DONE→IDLE) before the next acceptance, so throughput is one operation per NS+2 cycles with out_ready held at 1.
- in_valid, op_a, op_b and sub are ignored outside IDLE; changing them mid-operation has no effect.
- result is updated nibble-wise during RUN. Consumers must sample it only when out_valid=1.
- Wrap-around: the result is modulo 2^WIDTH, and the carry out of the MSB nibble appears only on carry_out.
- An out_ready pulse while not in DONE is ignored.
- in_valid and out_ready both high in DONE: the output is consumed, but the new request is not accepted until IDLE.
- WIDTH=4 degenerates to NS=1: the single RUN cycle goes straight to DONE.

Test Plan:
- WIDTH=16, add 0xFFFF+0x0001 -> result 0x0000, carry_out 1, overflow 0; out_valid exactly 4 cycles after the acceptance edge.
- Add 0x7FFF+0x0001 -> result 0x8000, carry_out 0, overflow 1. Add 0x1234+0x4321 -> result 0x5555, carry_out 0, overflow 0.
- Sub 0x0005-0x0007 -> result 0xFFFE, carry_out 0 (borrow), overflow 0. Sub 0x8000-0x0001 -> result 0x7FFF, carry_out 1, overflow 1.
- Back-pressure:
  - hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0 throughout;
  - toggle op_a during RUN -> result unaffected;
  - then out_ready=1 -> IDLE with in_ready=1 on the next cycle.
- Pull rst_n low during RUN at idx=2 -> outputs immediately zero, no out_valid. After release, a new request 0x0001+0x0001 -> result 0x0002.
- Back-to-back: in_valid and out_ready held at 1 with random operands for 500 operations -> every result matches a reference model (A±B mod 2^16, carry, overflow), one completion per 6 cycles.
